msrv32_pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the msrv32 core. It replaces fixed-field inter-stage registers with a generic WIDTH-bit payload register that has valid/ready handshaking, synchronous flush and a saturating back-pressure counter. An optional skid buffer gives full throughput with a registered `in_ready_out`. It sits between any two pipeline stages, for example between decode/operand-fetch and execute.

---
 rtl/msrv32_pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_msrv32_pipe_stage_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/msrv32_pipe_stage_reg.sv
// Flow-controlled msrv32 pipeline stage register with flush and a saturating stall counter.
// Define MSRV32_PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready_out.
module msrv32_pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] in_data_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] out_data_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

`ifdef MSRV32_PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;
`else
  typedef enum logic {ST_EMPTY = 1'b0, ST_ONE = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] stall_q;
  logic             in_xfer, out_xfer, stalled;

  assign out_valid_out = (state_q != ST_EMPTY);
  assign out_data_out  = m_q;
  assign stall_cnt_out = stall_q;
  assign in_xfer       = in_valid_in && in_ready_out;
  assign out_xfer      = out_valid_out && out_ready_in;
  assign stalled       = out_valid_out && !out_ready_in;

`ifdef MSRV32_PIPE_SKID_EN
  logic [WIDTH-1:0] s_q, s_d;
  logic             in_ready_q;

  // Ready comes straight from a flop, so out_ready_in never reaches in_ready_out.
  assign in_ready_out = in_ready_q;
`else
  assign in_ready_out = !out_valid_out || out_ready_in;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    m_d     = m_q;
`ifdef MSRV32_PIPE_SKID_EN
    s_d     = s_q;
`endif
    if (flush_in) begin
      state_d = ST_EMPTY;
      m_d     = RESET_VALUE;
`ifdef MSRV32_PIPE_SKID_EN
      s_d     = RESET_VALUE;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            m_d     = in_data_in;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_d = in_data_in;
`ifdef MSRV32_PIPE_SKID_EN
          end else if (in_xfer) begin
            state_d = ST_TWO;
            s_d     = in_data_in;
`endif
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef MSRV32_PIPE_SKID_EN
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: asynchronous reset sits in the sensitivity list; state uses non-blocking assignment.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_EMPTY;
      m_q     <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

`ifdef MSRV32_PIPE_SKID_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s_q        <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      s_q        <= s_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end
`endif

  // Back-pressure counter includes the flush cycle and sticks at all-ones.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      stall_q <= '0;
    end else if (stalled && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
// Self-checking bench for msrv32_pipe_stage_reg: scoreboard of accepted payloads plus directed checks.
// Follows MSRV32_PIPE_SKID_EN to pick the expected in_ready behaviour.
module tb_msrv32_pipe_stage_reg;

`ifdef MSRV32_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        flush_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] in_data_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] out_data_out;
  logic [15:0] stall_cnt_out;

  logic        c2_flush, c2_in_valid, c2_in_ready, c2_out_valid, c2_out_ready;
  logic [7:0]  c2_in_data, c2_out_data;
  logic [1:0]  c2_stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_stall = '0;

  always #5 clk_in = ~clk_in;

  msrv32_pipe_stage_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out), .in_data_in(in_data_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in), .out_data_out(out_data_out),
    .stall_cnt_out(stall_cnt_out)
  );

  msrv32_pipe_stage_reg #(.WIDTH(8), .CNT_W(2)) dut_c2 (
    .clk_in(clk_in), .reset_in(reset_in), .flush_in(c2_flush),
    .in_valid_in(c2_in_valid), .in_ready_out(c2_in_ready), .in_data_in(c2_in_data),
    .out_valid_out(c2_out_valid), .out_ready_in(c2_out_ready), .out_data_out(c2_out_data),
    .stall_cnt_out(c2_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; runs one full clock cycle.
  task automatic tick();
    logic        exp_valid;
    logic        exp_rdy;
    logic [31:0] exp_data;
    #1;
    exp_valid = (sb.size() != 0);
    exp_rdy   = SKID ? (sb.size() < 2) : (!exp_valid || out_ready_in);
    check("out_valid", {63'd0, out_valid_out}, {63'd0, exp_valid});
    check("in_ready", {63'd0, in_ready_out}, {63'd0, exp_rdy});
    if (exp_valid && out_ready_in) begin
      exp_data = sb.pop_front();
      check("out_data", {32'd0, out_data_out}, {32'd0, exp_data});
    end
    if (in_valid_in && in_ready_out && !flush_in) sb.push_back(in_data_in);
    if (flush_in) sb.delete();
    if (exp_valid && !out_ready_in && exp_stall != 16'hFFFF) exp_stall++;
    @(posedge clk_in);
    #1;
    check("stall_cnt", {48'd0, stall_cnt_out}, {48'd0, exp_stall});
    @(negedge clk_in);
  endtask

  initial begin
    int          exp_c2[6];
    logic [31:0] seq[4];
    exp_c2 = '{1, 2, 3, 3, 3, 3};
    seq    = '{32'h11, 32'h22, 32'h33, 32'h44};

    reset_in = 1'b1; flush_in = 1'b0; in_valid_in = 1'b0; in_data_in = '0; out_ready_in = 1'b0;
    c2_flush = 1'b0; c2_in_valid = 1'b0; c2_in_data = '0; c2_out_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    check("rst_valid", {63'd0, out_valid_out}, 64'd0);
    check("rst_ready", {63'd0, in_ready_out}, 64'd1);
    check("rst_data", {32'd0, out_data_out}, 64'd0);
    check("rst_stall", {48'd0, stall_cnt_out}, 64'd0);
    @(negedge clk_in);

    // Back-to-back stream with downstream always ready.
    out_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_in = 1'b1;
      in_data_in  = seq[i];
      tick();
    end
    in_valid_in = 1'b0;
    tick();
    check("stream_drained", 64'(sb.size()), 64'd0);
    check("stream_stall", {48'd0, stall_cnt_out}, 64'd0);

    // 0xA then 0xB under back-pressure, then release.
    out_ready_in = 1'b0;
    in_valid_in = 1'b1; in_data_in = 32'hA;
    tick();
    in_data_in = 32'hB;
    tick();
    #1;
    check("hold_ready", {63'd0, in_ready_out}, 64'd0);
    check("hold_data", {32'd0, out_data_out}, 64'hA);
    tick();
    tick();
    check("hold_stall", {48'd0, stall_cnt_out}, 64'd3);
    out_ready_in = 1'b1;
    tick();
    in_valid_in = 1'b0;
    tick();
    check("hold_drained", 64'(sb.size()), 64'd0);

    // Flush with an entry held and 0xC offered, then flush with an acceptable input.
    out_ready_in = 1'b0;
    in_valid_in = 1'b1; in_data_in = 32'hA;
    tick();
    in_data_in = 32'hB;
    tick();
    flush_in = 1'b1; in_data_in = 32'hC;
    tick();
    check("flush_valid", {63'd0, out_valid_out}, 64'd0);
    check("flush_data", {32'd0, out_data_out}, 64'd0);
    check("flush_stall", {48'd0, stall_cnt_out}, 64'd5);
    in_data_in = 32'hD;
    tick();
    flush_in = 1'b0; in_valid_in = 1'b0;
    tick();

    // Saturation of a 2-bit counter.
    c2_in_valid = 1'b1; c2_in_data = 8'h5A;
    @(posedge clk_in);
    @(negedge clk_in);
    c2_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in);
      #1;
      check("c2_stall", {62'd0, c2_stall}, 64'(exp_c2[i]));
    end
    check("c2_data", {56'd0, c2_out_data}, 64'h5A);
    @(negedge clk_in);

    // Random traffic against the scoreboard, then drain.
    for (int i = 0; i < 60; i++) begin
      in_valid_in  = 1'($urandom_range(0, 1));
      in_data_in   = $urandom;
      out_ready_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid_in = 1'b0; out_ready_in = 1'b1;
    repeat (3) tick();
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset between edges while one entry is held.
    out_ready_in = 1'b0; in_valid_in = 1'b1; in_data_in = 32'h55;
    tick();
    in_valid_in = 1'b0;
    #3;
    reset_in = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid_out}, 64'd0);
    check("arst_ready", {63'd0, in_ready_out}, 64'd1);
    check("arst_data", {32'd0, out_data_out}, 64'd0);
    check("arst_stall", {48'd0, stall_cnt_out}, 64'd0);
    check("arst_c2_stall", {62'd0, c2_stall}, 64'd0);
    sb.delete();
    exp_stall = '0;
    @(negedge clk_in);
    reset_in = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
